maj_tt_engine: RTL and testbench



---
 rtl/maj_tt_pkg.sv | 42 ++++
 rtl/maj_net_eval.sv | 55 +++++
 rtl/maj_tt_engine.sv | 164 ++++++++++++++++
 tb/tb_maj_tt_engine.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/maj_tt_pkg.sv
// Shared types and helpers for the majority-network truth-table engine.
//   - Operand code layout: 0 = constant 0, 1..NUM_IN = x[code-1], NUM_IN+1+k = gate k.
//   - Operand / gate configuration structs. The sel field is sized for the largest
//     supported network, and the engine zero-extends the narrower written codes into it.
//   - FSM state encoding.
package maj_tt_pkg;

    // Widest operand code the stored configuration can hold.
    localparam int unsigned SEL_W_MAX = 8;

    localparam int unsigned OP_ZERO    = 0;
    localparam int unsigned OP_IN_BASE = 1;

    // First gate code for a given input count.
    function automatic int unsigned op_gate_base(input int unsigned num_in);
        return OP_IN_BASE + num_in;
    endfunction

    // Operand select width: covers constant 0, all inputs and all gates.
    function automatic int unsigned sel_w(input int unsigned num_in, input int unsigned num_gates);
        return $clog2(1 + num_in + num_gates);
    endfunction

    typedef struct packed {
        logic                 inv;
        logic [SEL_W_MAX-1:0] sel;
    } operand_cfg_t;

    typedef struct packed {
        operand_cfg_t c;
        operand_cfg_t b;
        operand_cfg_t a;
    } gate_cfg_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_t;

endpackage

// File: rtl/maj_net_eval.sv
// Combinational evaluator for a configurable network of 3-input majority gates.
//   gate_cfg : per-gate operand selects/inversions
//   out_cfg  : output node select/inversion
//   minterm  : input assignment, x[i] = minterm[i]
//   f        : network output for this minterm
// A gate can only see gates with a lower index; forward/self references and out-of-range
// codes read as 0 before inversion.
module maj_net_eval
    import maj_tt_pkg::*;
#(
    parameter int unsigned NUM_IN    = 7,
    parameter int unsigned NUM_GATES = 5
) (
    input  gate_cfg_t [NUM_GATES-1:0] gate_cfg,
    input  operand_cfg_t              out_cfg,
    input  logic [NUM_IN-1:0]         minterm,
    output logic                      f
);

    localparam int NODES = 1 + NUM_IN + NUM_GATES;

    logic [NODES-1:0] node;

    // Compare-and-select mux rather than a variable index, so codes at or above `limit`
    // (including codes past the last node) fall through to 0.
    function automatic logic pick(input logic [NODES-1:0] nodes, input operand_cfg_t op,
                                  input int limit);
        logic v;
        v = 1'b0;
        for (int c = 1; c < NODES; c++) begin
            if (c < limit && int'(op.sel) == c) begin
                v = nodes[c];
            end
        end
        return v ^ op.inv;
    endfunction

    always_comb begin
        logic va, vb, vc;
        va = 1'b0;
        vb = 1'b0;
        vc = 1'b0;
        node = '0;
        node[NUM_IN:1] = minterm;
        // Gates are resolved in index order; each gate's limit excludes itself and later gates.
        for (int k = 0; k < NUM_GATES; k++) begin
            va = pick(node, gate_cfg[k].a, int'(op_gate_base(NUM_IN)) + k);
            vb = pick(node, gate_cfg[k].b, int'(op_gate_base(NUM_IN)) + k);
            vc = pick(node, gate_cfg[k].c, int'(op_gate_base(NUM_IN)) + k);
            node[int'(op_gate_base(NUM_IN)) + k] = (va & vb) | (va & vc) | (vb & vc);
        end
        f = pick(node, out_cfg, NODES);
    end

endmodule

// File: rtl/maj_tt_engine.sv
// Sweeps all 2^NUM_IN minterms through a programmable majority network, one per cycle,
// and streams the packed truth table out in WORD_W-bit words with a valid/ready handshake.
//   clk, rst_n  : clock, asynchronous active-low reset (also clears configuration)
//   cfg_we/addr/data : configuration write, accepted only while not busy;
//                 addr < NUM_GATES writes a gate {inv_c,sel_c,inv_b,sel_b,inv_a,sel_a},
//                 addr == NUM_GATES writes the output node {inv,sel} in the low bits
//   start       : begin a sweep (ignored unless idle)
//   busy        : sweep in progress
//   tt_data/tt_idx/tt_valid/tt_ready : truth-table word stream, bit j = f(idx*WORD_W+j)
//   done        : one-cycle pulse at sweep end
//   ones_cnt    : count of minterms with f=1
module maj_tt_engine
    import maj_tt_pkg::*;
#(
    parameter int unsigned NUM_IN    = 7,
    parameter int unsigned NUM_GATES = 5,
    parameter int unsigned WORD_W    = 32
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       cfg_we,
    input  logic [$clog2(NUM_GATES+1)-1:0]             cfg_addr,
    input  logic [3*(sel_w(NUM_IN, NUM_GATES)+1)-1:0]  cfg_data,
    input  logic                                       start,
    output logic                                       busy,
    output logic [WORD_W-1:0]                          tt_data,
    output logic [NUM_IN-$clog2(WORD_W)-1:0]           tt_idx,
    output logic                                       tt_valid,
    input  logic                                       tt_ready,
    output logic                                       done,
    output logic [NUM_IN:0]                            ones_cnt
);

    localparam int unsigned SEL_W  = sel_w(NUM_IN, NUM_GATES);
    localparam int unsigned ADDR_W = $clog2(NUM_GATES + 1);
    localparam int unsigned WB     = $clog2(WORD_W);
    localparam int unsigned IDX_W  = NUM_IN - WB;
    localparam int unsigned CNT_W  = NUM_IN + 1;

    gate_cfg_t [NUM_GATES-1:0] gate_cfg_q;
    operand_cfg_t              out_cfg_q;

    state_t             state_q;
    logic [NUM_IN-1:0]  m_q;
    logic [WORD_W-1:0]  acc_q;
    logic [WORD_W-1:0]  acc_next;
    logic [WORD_W-1:0]  tt_data_q;
    logic [IDX_W-1:0]   tt_idx_q;
    logic               tt_valid_q;
    logic [CNT_W-1:0]   ones_q;
    logic               busy_q;
    logic               done_q;

    logic f;
    logic stall;
    logic word_last;
    logic sweep_last;

    function automatic operand_cfg_t unpack_op(input logic [SEL_W:0] bits);
        operand_cfg_t op;
        op.inv = bits[SEL_W];
        op.sel = SEL_W_MAX'(bits[SEL_W-1:0]);
        return op;
    endfunction

    maj_net_eval #(
        .NUM_IN    (NUM_IN),
        .NUM_GATES (NUM_GATES)
    ) u_eval (
        .gate_cfg (gate_cfg_q),
        .out_cfg  (out_cfg_q),
        .minterm  (m_q),
        .f        (f)
    );

    // Holding m whenever a word is pending and not taken keeps the accumulator from
    // completing over an unconsumed output word.
    assign stall      = tt_valid_q && !tt_ready;
    assign word_last  = (m_q & NUM_IN'(WORD_W - 1)) == NUM_IN'(WORD_W - 1);
    assign sweep_last = &m_q;
    // Shift in from the top so after WORD_W captures bit j holds minterm j of the word.
    assign acc_next   = (WORD_W'(f) << (WORD_W - 1)) | (acc_q >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cfg_q <= '0;
            out_cfg_q  <= '0;
        end else if (cfg_we && !busy_q) begin
            if (cfg_addr == ADDR_W'(NUM_GATES)) begin
                out_cfg_q <= unpack_op(cfg_data[SEL_W:0]);
            end else if (cfg_addr < ADDR_W'(NUM_GATES)) begin
                gate_cfg_q[cfg_addr].a <= unpack_op(cfg_data[SEL_W:0]);
                gate_cfg_q[cfg_addr].b <= unpack_op(cfg_data[2*SEL_W+1:SEL_W+1]);
                gate_cfg_q[cfg_addr].c <= unpack_op(cfg_data[3*SEL_W+2:2*SEL_W+2]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            m_q        <= '0;
            acc_q      <= '0;
            tt_data_q  <= '0;
            tt_idx_q   <= '0;
            tt_valid_q <= 1'b0;
            ones_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // A newly completed word below overrides this clear on the same edge.
            if (tt_valid_q && tt_ready) begin
                tt_valid_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                        m_q     <= '0;
                        ones_q  <= '0;
                    end
                end
                StRun: begin
                    if (!stall) begin
                        acc_q  <= acc_next;
                        ones_q <= ones_q + CNT_W'(f);
                        m_q    <= m_q + 1'b1;
                        if (word_last) begin
                            tt_data_q  <= acc_next;
                            tt_idx_q   <= IDX_W'(m_q >> WB);
                            tt_valid_q <= 1'b1;
                            if (sweep_last) begin
                                state_q <= StDrain;
                            end
                        end
                    end
                end
                StDrain: begin
                    if (tt_valid_q && tt_ready) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign tt_data  = tt_data_q;
    assign tt_idx   = tt_idx_q;
    assign tt_valid = tt_valid_q;
    assign done     = done_q;
    assign ones_cnt = ones_q;

endmodule

// File: tb/tb_maj_tt_engine.sv
// Directed bench for maj_tt_engine with default parameters (7 inputs, 5 gates, 32-bit words).
module tb_maj_tt_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [14:0] cfg_data = '0;
    logic        start = 1'b0;
    logic        tt_ready = 1'b1;
    logic        busy;
    logic [31:0] tt_data;
    logic [1:0]  tt_idx;
    logic        tt_valid;
    logic        done;
    logic [7:0]  ones_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_data[$];
    logic [1:0]  got_idx[$];
    int          done_at;
    int          stall_errs;
    logic        done_next;
    logic        busy_after_start;

    always #5 clk = ~clk;

    maj_tt_engine #(
        .NUM_IN    (7),
        .NUM_GATES (5),
        .WORD_W    (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .start    (start),
        .busy     (busy),
        .tt_data  (tt_data),
        .tt_idx   (tt_idx),
        .tt_valid (tt_valid),
        .tt_ready (tt_ready),
        .done     (done),
        .ones_cnt (ones_cnt)
    );

    function automatic logic [4:0] op(input logic inv, input logic [3:0] sel);
        return {inv, sel};
    endfunction

    function automatic logic [14:0] gate(input logic [4:0] a, input logic [4:0] b,
                                         input logic [4:0] c);
        return {c, b, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [14:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    // Runs one sweep from idle, recording every handshaken word and the cycle (relative to
    // the start edge) at which done is first seen. Optional pokes: a second start at cycle 20
    // and a configuration write (output inversion) at cycle 40, both while busy.
    task automatic run_sweep(input bit rand_ready, input bit poke_start, input bit poke_cfg);
        logic [31:0] held_data;
        logic [1:0]  held_idx;
        bit          stalled;
        got_data.delete();
        got_idx.delete();
        done_at    = -1;
        stall_errs = 0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start            = 1'b0;
        busy_after_start = busy;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            tt_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
            start    = poke_start && (cyc == 20);
            cfg_we   = poke_cfg && (cyc == 40);
            cfg_addr = 3'd5;
            cfg_data = {10'd0, op(1'b1, 4'd8)};
            stalled   = tt_valid && !tt_ready;
            held_data = tt_data;
            held_idx  = tt_idx;
            if (tt_valid && tt_ready) begin
                got_data.push_back(tt_data);
                got_idx.push_back(tt_idx);
            end
            @(posedge clk);
            #1;
            if (stalled && (!tt_valid || tt_data !== held_data || tt_idx !== held_idx)) begin
                stall_errs++;
            end
            if (done) begin
                done_at = cyc;
                break;
            end
        end
        start    = 1'b0;
        cfg_we   = 1'b0;
        tt_ready = 1'b1;
        @(posedge clk);
        #1;
        done_next = done;
    endtask

    task automatic check_sweep(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3,
                               input logic [7:0] ones);
        logic [31:0] exp_w[4];
        exp_w = '{w0, w1, w2, w3};
        check({tag, "_nwords"}, 64'(got_data.size()), 64'd4);
        if (got_data.size() == 4) begin
            for (int w = 0; w < 4; w++) begin
                check($sformatf("%s_data%0d", tag, w), 64'(got_data[w]), 64'(exp_w[w]));
                check($sformatf("%s_idx%0d", tag, w), 64'(got_idx[w]), 64'(w));
            end
        end
        check({tag, "_ones"}, 64'(ones_cnt), 64'(ones));
        check({tag, "_done_pulse"}, 64'(done_next), 64'd0);
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(tt_valid), 64'd0);
        check("rst_data", 64'(tt_data), 64'd0);
        check("rst_idx", 64'(tt_idx), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ones", 64'(ones_cnt), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // MAJ(x0,x0,0) = x0 -> odd minterms set
        cfg_write(3'd0, gate(op(1'b0, 4'd1), op(1'b0, 4'd1), op(1'b0, 4'd0)));
        cfg_write(3'd5, {10'd0, op(1'b0, 4'd8)});
        run_sweep(1'b0, 1'b0, 1'b0);
        check("x0_busy_start", 64'(busy_after_start), 64'd1);
        check("x0_done_at", 64'(done_at), 64'd129);
        check_sweep("x0", 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 8'd64);

        // MAJ(x0,x1,0) = AND, then inverted output = NAND
        cfg_write(3'd0, gate(op(1'b0, 4'd1), op(1'b0, 4'd2), op(1'b0, 4'd0)));
        run_sweep(1'b0, 1'b0, 1'b0);
        check_sweep("and", 32'h8888_8888, 32'h8888_8888, 32'h8888_8888, 32'h8888_8888, 8'd32);
        cfg_write(3'd5, {10'd0, op(1'b1, 4'd8)});
        run_sweep(1'b0, 1'b0, 1'b0);
        check_sweep("nand", 32'h7777_7777, 32'h7777_7777, 32'h7777_7777, 32'h7777_7777, 8'd96);

        // Output taken straight from x6 (gate0 = OR, unused), ready held then random
        cfg_write(3'd0, gate(op(1'b0, 4'd1), op(1'b0, 4'd2), op(1'b1, 4'd0)));
        cfg_write(3'd5, {10'd0, op(1'b0, 4'd7)});
        run_sweep(1'b0, 1'b0, 1'b0);
        check_sweep("x6", 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd64);
        run_sweep(1'b1, 1'b0, 1'b0);
        check("x6r_done_seen", 64'(done_at > 0), 64'd1);
        check("x6r_stall_stable", 64'(stall_errs), 64'd0);
        check_sweep("x6r", 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd64);

        // Forward reference reads 0: MAJ(gate1,x0,x0) = x0 even with gate1 = 1.
        // Pokes: second start and an output-inverting cfg write while busy, both ignored.
        cfg_write(3'd1, gate(op(1'b1, 4'd0), op(1'b1, 4'd0), op(1'b1, 4'd0)));
        cfg_write(3'd0, gate(op(1'b0, 4'd9), op(1'b0, 4'd1), op(1'b0, 4'd1)));
        cfg_write(3'd5, {10'd0, op(1'b0, 4'd8)});
        run_sweep(1'b0, 1'b1, 1'b1);
        check("fwd_done_at", 64'(done_at), 64'd129);
        check_sweep("fwd", 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 8'd64);
        run_sweep(1'b0, 1'b0, 1'b0);
        check_sweep("fwd2", 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 8'd64);

        // MAJ(gate1,x0,0): forward reference as 0 gives constant 0
        cfg_write(3'd0, gate(op(1'b0, 4'd9), op(1'b0, 4'd1), op(1'b0, 4'd0)));
        run_sweep(1'b0, 1'b0, 1'b0);
        check_sweep("fwd0", 32'h0, 32'h0, 32'h0, 32'h0, 8'd0);

        // Out-of-range output code 15 reads 0, inverted -> all ones, full count
        cfg_write(3'd5, {10'd0, op(1'b1, 4'd15)});
        run_sweep(1'b0, 1'b0, 1'b0);
        check_sweep("oor", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd128);

        // Reset mid-sweep with output = x0
        cfg_write(3'd5, {10'd0, op(1'b0, 4'd1)});
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("mid_ones", 64'(ones_cnt), 64'd25);
        check("mid_data", 64'(tt_data), 64'hAAAA_AAAA);
        check("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_valid", 64'(tt_valid), 64'd0);
        check("arst_data", 64'(tt_data), 64'd0);
        check("arst_idx", 64'(tt_idx), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_ones", 64'(ones_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_sweep(1'b0, 1'b0, 1'b0);
        check("post_rst_done_at", 64'(done_at), 64'd129);
        check_sweep("post_rst", 32'h0, 32'h0, 32'h0, 32'h0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
